// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch stage feeding the decoder.
// Fetches 32-bit words from instruction memory (one request outstanding),
// buffers them in a circular prefetch queue and issues one word at a time
// on ir with a single-cycle cs strobe. A redirect flushes the queue and
// reloads the PC; a response already in flight is completed and dropped.
// Optional feature: define IFETCH_PERF_CNT_EN to add the fetch_cnt output,
// a saturating count of cs pulses.
module ifetch_queue #(
    parameter int                  ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int                  QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_valid,
    output logic [31:0]       ir,
    output logic              cs,
    input  logic              ready1,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [15:0]       fetch_cnt
`endif
);

    localparam int               PTR_W  = $clog2(QDEPTH);
    localparam logic [PTR_W:0]   Q_FULL = (PTR_W+1)'(QDEPTH);

    localparam logic [0:0] F_IDLE  = 1'b0;
    localparam logic [0:0] F_WAIT  = 1'b1;

    localparam logic [1:0] I_IDLE  = 2'd0;
    localparam logic [1:0] I_ISSUE = 2'd1;
    localparam logic [1:0] I_HOLD  = 2'd2;

    logic [0:0]        f_state;
    logic [1:0]        i_state;
    logic [ADDR_W-1:0] pc;
    logic              drop;

    logic [31:0]       q_mem [QDEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;

    logic              fetch_start;
    logic              push;
    logic              pop;

    // Handshake qualifiers shared by the fetch, queue and issue logic
    always_comb begin
        fetch_start = (f_state == F_IDLE) && (count != Q_FULL) && !redirect;
        push        = (f_state == F_WAIT) && mem_valid && !drop && !redirect;
        pop         = (i_state == I_IDLE) && ready1 && (count != '0) && !redirect;
    end

    // Fetch FSM: issue a read, wait for completion, advance or reload the PC.
    // The redirect block sits after the case so it overrides pc and sets the
    // drop flag for a response that is still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_state  <= F_IDLE;
            mem_rd   <= 1'b0;
            mem_addr <= RESET_PC;
            pc       <= RESET_PC;
            drop     <= 1'b0;
        end else begin
            case (f_state)
                F_IDLE: begin
                    if (fetch_start) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= pc;
                        f_state  <= F_WAIT;
                    end
                end
                F_WAIT: begin
                    if (mem_valid) begin
                        mem_rd  <= 1'b0;
                        f_state <= F_IDLE;
                        drop    <= 1'b0;
                        if (!drop && !redirect) begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                default: begin
                    f_state <= F_IDLE;
                    mem_rd  <= 1'b0;
                end
            endcase
            if (redirect) begin
                pc <= redirect_pc;
                if ((f_state == F_WAIT) && !mem_valid) begin
                    drop <= 1'b1;
                end
            end
        end
    end

    // Queue storage; contents are don't-care while count is zero
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= mem_rdata;
        end
    end

    // Queue pointers and occupancy; redirect flushes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issue FSM: pop the head into ir with a one-cycle cs, then hold a cycle
    // so the decoder has time to drop ready1 after sampling cs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_state <= I_IDLE;
            ir      <= '0;
            cs      <= 1'b0;
        end else begin
            case (i_state)
                I_IDLE: begin
                    if (pop) begin
                        ir      <= q_mem[rd_ptr];
                        cs      <= 1'b1;
                        i_state <= I_ISSUE;
                    end
                end
                I_ISSUE: begin
                    cs      <= 1'b0;
                    i_state <= I_HOLD;
                end
                I_HOLD: begin
                    i_state <= I_IDLE;
                end
                default: begin
                    cs      <= 1'b0;
                    i_state <= I_IDLE;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // Saturating count of issued instructions; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
        end else if (pop && (fetch_cnt != 16'hFFFF)) begin
            fetch_cnt <= fetch_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed bench for ifetch_queue with a behavioural
// instruction memory (word at address A is {16'hC0DE, A}, latency mem_lat).
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;
    logic [31:0] ir;
    logic        cs;
    logic        ready1 = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_lat = 1;
    int wcnt = 0;
    int push_cyc = -1;
    logic prev_rd = 1'b0;

    logic [15:0] req_q[$];
    logic [31:0] ir_q[$];
    int          cs_cyc_q[$];

    ifetch_queue #(.ADDR_W(16), .RESET_PC(16'h0000), .QDEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .ir         (ir),
        .cs         (cs),
        .ready1     (ready1),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: answers each request mem_lat negedges after seeing mem_rd
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_valid = 1'b0;
            wcnt = 0;
        end else if (mem_valid) begin
            mem_valid = 1'b0;
        end else if (mem_rd) begin
            wcnt++;
            if (wcnt >= mem_lat) begin
                mem_valid = 1'b1;
                mem_rdata = {16'hC0DE, mem_addr};
                wcnt = 0;
                if (push_cyc < 0) push_cyc = cyc + 1;
            end
        end
    end

    // Monitor: log request addresses and issued words
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd && !prev_rd) req_q.push_back(mem_addr);
            if (cs) begin
                ir_q.push_back(ir);
                cs_cyc_q.push_back(cyc);
            end
        end
        prev_rd = mem_rd;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        check_eq("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        check_eq("rst_mem_addr", {16'b0, mem_addr}, 32'h0000);
        check_eq("rst_ir", ir, 32'd0);
        check_eq("rst_cs", {31'b0, cs}, 32'd0);
        req_q.delete();
        ir_q.delete();
        cs_cyc_q.delete();
        push_cyc = -1;
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string tag, input int n);
        for (int i = 0; i < 200 && req_q.size() < n; i++) step();
        check_eq(tag, req_q.size(), n);
    endtask

    task automatic wait_ir(input string tag, input int n);
        for (int i = 0; i < 200 && ir_q.size() < n; i++) step();
        check_eq(tag, ir_q.size(), n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming with ready1 high and single-cycle memory
        ready1 = 1'b1;
        mem_lat = 1;
        do_reset();
        step(40);
        for (int i = 0; i < 4; i++) check_eq("t1_addr", {16'b0, req_q[i]}, i);
        check_eq("t1_ir0", ir_q[0], 32'hC0DE0000);
        check_eq("t1_ir1", ir_q[1], 32'hC0DE0001);
        check_eq("t1_ir2", ir_q[2], 32'hC0DE0002);
        check_eq("t1_push_to_cs", cs_cyc_q[0], push_cyc + 1);
        for (int i = 1; i < 4; i++) check_eq("t1_cs_spacing", cs_cyc_q[i] - cs_cyc_q[i-1], 3);

        // Decoder stalled: queue fills to 4, then drains in order
        ready1 = 1'b0;
        do_reset();
        step(30);
        check_eq("t2_nreq", req_q.size(), 4);
        for (int i = 0; i < 4; i++) check_eq("t2_addr", {16'b0, req_q[i]}, i);
        check_eq("t2_rd_idle", {31'b0, mem_rd}, 32'd0);
        check_eq("t2_no_cs", ir_q.size(), 0);
        req_q.delete();
        ready1 = 1'b1;
        step(20);
        for (int i = 0; i < 4; i++) check_eq("t2_drain_ir", ir_q[i], 32'hC0DE0000 + i);
        check_eq("t2_resume_addr", {16'b0, req_q[0]}, 32'h0004);

        // Redirect while address 2 is in flight with slow memory
        ready1 = 1'b0;
        mem_lat = 3;
        do_reset();
        wait_req("t3_wait_req", 3);
        check_eq("t3_inflight_addr", {16'b0, req_q[2]}, 32'h0002);
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        req_q.delete();
        step(30);
        check_eq("t3_next_addr", {16'b0, req_q[0]}, 32'h0040);
        check_eq("t3_next_addr2", {16'b0, req_q[1]}, 32'h0041);
        ready1 = 1'b1;
        step(30);
        check_eq("t3_first_ir", ir_q[0], 32'hC0DE0040);
        check_eq("t3_second_ir", ir_q[1], 32'hC0DE0041);

        // Redirect on the edge where an issue would otherwise happen
        ready1 = 1'b0;
        mem_lat = 1;
        do_reset();
        wait_req("t4_wait_req", 3);
        ready1 = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        step();
        redirect = 1'b0;
        check_eq("t4_cs_suppressed", {31'b0, cs}, 32'd0);
        check_eq("t4_ir_held", ir, 32'd0);
        step(30);
        check_eq("t4_first_ir", ir_q[0], 32'hC0DE0100);

        // PC wrap at the top of the address space
        redirect = 1'b1;
        redirect_pc = 16'hFFFF;
        step();
        redirect = 1'b0;
        req_q.delete();
        ir_q.delete();
        step(30);
        check_eq("t5_addr_top", {16'b0, req_q[0]}, 32'h0000FFFF);
        check_eq("t5_addr_wrap", {16'b0, req_q[1]}, 32'h00000000);
        check_eq("t5_ir_top", ir_q[0], 32'hC0DEFFFF);
        check_eq("t5_ir_wrap", ir_q[1], 32'hC0DE0000);

        // Asynchronous reset in the middle of an issue
        ready1 = 1'b1;
        mem_lat = 1;
        do_reset();
        wait_ir("t6_wait_ir", 5);
        check_eq("t6_cs_high", {31'b0, cs}, 32'd1);
`ifdef IFETCH_PERF_CNT_EN
        check_eq("t6_fetch_cnt", {16'b0, fetch_cnt}, 32'd5);
`endif
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_cs", {31'b0, cs}, 32'd0);
        check_eq("t6_async_rd", {31'b0, mem_rd}, 32'd0);
        check_eq("t6_async_ir", ir, 32'd0);
        check_eq("t6_async_addr", {16'b0, mem_addr}, 32'h0000);
`ifdef IFETCH_PERF_CNT_EN
        check_eq("t6_async_cnt", {16'b0, fetch_cnt}, 32'd0);
`endif
        step(2);
        rst_n = 1'b1;
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
